// File: rtl/crc_err_supervisor_pkg.sv
// Purpose : shared types and helpers for the CRC error supervisor.
// Contents: supervisor state enum, memory channel indices, and a
//           lowest-set-bit helper used for fault attribution.
package crc_sup_pkg;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_WARN  = 2'd1,
    ST_FAULT = 2'd2
  } sup_state_e;

  localparam int CH_MEM1    = 0;  // ASIL-D memory, tight threshold
  localparam int CH_MEM2    = 1;  // ASIL-B memory, loose threshold
  localparam int SUP_NUM_CH = 2;

  // Index of the lowest set bit; 0 when no bit is set, which is also the
  // cleared value of the fault channel register.
  function automatic logic lowest_set_idx(input logic [SUP_NUM_CH-1:0] v);
    logic idx;
    idx = 1'b0;
    for (int i = SUP_NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = 1'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/crc_err_counter.sv
// Purpose : per-channel corrected-error counter with leaky-bucket decay.
// Ports   : clk, rst (sync, active-high)
//           inc       - corrected-error event this cycle
//           leak      - leak tick this cycle
//           threshold - warn level for this channel
//           count     - registered saturating count
//           ovr       - next count value is at or above threshold
module crc_err_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 leak,
  input  logic [CNT_WIDTH-1:0] threshold,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovr
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_nxt;

  // An increment and a leak in the same cycle cancel, even at saturation.
  always_comb begin
    w_count_nxt = r_count;
    if (inc && !leak) begin
      if (r_count != CNT_MAX) w_count_nxt = r_count + CNT_WIDTH'(1);
    end else if (leak && !inc) begin
      if (r_count != '0) w_count_nxt = r_count - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= w_count_nxt;
  end

  // Looks at the next value so the FSM escalates in the same cycle the
  // counter reaches its threshold.
  assign ovr   = (w_count_nxt >= threshold);
  assign count = r_count;

endmodule

// File: rtl/crc_err_supervisor.sv
// Purpose : safety supervisor for the crc_mem error strobes. Counts
//           corrected errors per channel with leaky decay and escalates to
//           a global WARN / sticky FAULT state with software acknowledge.
// Ports   : clk, rst (sync, active-high)
//           err_detected, err_corrected - per-channel strobes
//           fault_ack    - acknowledge of a latched fault
//           warn, fault  - registered state indications
//           fault_ch     - first channel that caused the current fault
//           uncorr_flags - sticky per-channel uncorrectable flags
//           corr_cnt     - packed counters, channel 0 in the LSBs
//           irq          - one-cycle pulse on every state change
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_OK    | all counters below threshold, no fault latched
// ST_WARN  | at least one counter at/above its threshold
// ST_FAULT | uncorrectable error latched, waiting for fault_ack
module crc_err_supervisor
  import crc_sup_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int CNT_WIDTH     = 8,
  parameter int CORR_THRESH_0 = 4,
  parameter int CORR_THRESH_1 = 16,
  parameter int LEAK_PERIOD   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           err_detected,
  input  logic [NUM_CH-1:0]           err_corrected,
  input  logic                        fault_ack,
  output logic                        warn,
  output logic                        fault,
  output logic                        fault_ch,
  output logic [NUM_CH-1:0]           uncorr_flags,
  output logic [NUM_CH*CNT_WIDTH-1:0] corr_cnt,
  output logic                        irq
);

  localparam int               LEAK_W    = $clog2(LEAK_PERIOD);
  localparam logic [LEAK_W-1:0] LEAK_LAST = LEAK_W'(LEAK_PERIOD - 1);

  logic [NUM_CH-1:0] w_corr;
  logic [NUM_CH-1:0] w_uncorr;
  logic [NUM_CH-1:0] w_ovr;
  logic              w_any_uncorr;
  logic              w_any_ovr;

  // A corrected strobe counts even without err_detected.
  assign w_corr       = err_corrected;
  assign w_uncorr     = err_detected & ~err_corrected;
  assign w_any_uncorr = |w_uncorr;
  assign w_any_ovr    = |w_ovr;

  // Leak timer
  logic [LEAK_W-1:0] r_leak_cnt;
  logic              w_leak_tick;

  assign w_leak_tick = (r_leak_cnt == LEAK_LAST);

  always_ff @(posedge clk) begin
    if (rst)              r_leak_cnt <= '0;
    else if (w_leak_tick) r_leak_cnt <= '0;
    else                  r_leak_cnt <= r_leak_cnt + LEAK_W'(1);
  end

  // Per-channel counters
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int TH = (c == CH_MEM1) ? CORR_THRESH_0 : CORR_THRESH_1;

    crc_err_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_corr[c]),
      .leak      (w_leak_tick),
      .threshold (CNT_WIDTH'(TH)),
      .count     (corr_cnt[c*CNT_WIDTH +: CNT_WIDTH]),
      .ovr       (w_ovr[c])
    );
  end

  // FSM
  sup_state_e r_state;
  sup_state_e w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OK: begin
        if (w_any_uncorr)   w_state_nxt = ST_FAULT;
        else if (w_any_ovr) w_state_nxt = ST_WARN;
      end
      ST_WARN: begin
        if (w_any_uncorr)    w_state_nxt = ST_FAULT;
        else if (!w_any_ovr) w_state_nxt = ST_OK;
      end
      ST_FAULT: begin
        // A new uncorrectable event coincident with the ack keeps us here.
        if (fault_ack && !w_any_uncorr) w_state_nxt = w_any_ovr ? ST_WARN : ST_OK;
      end
      default: w_state_nxt = ST_OK;
    endcase
  end

  // Fault latching
  logic [NUM_CH-1:0] r_flags;
  logic [NUM_CH-1:0] w_flags_nxt;
  logic              r_fault_ch;
  logic              w_fault_ch_nxt;

  always_comb begin
    w_flags_nxt    = r_flags;
    w_fault_ch_nxt = r_fault_ch;
    if (r_state != ST_FAULT) begin
      if (w_any_uncorr) begin
        w_flags_nxt    = w_uncorr;
        w_fault_ch_nxt = lowest_set_idx(w_uncorr);
      end
    end else if (fault_ack) begin
      // Ack reloads with this cycle's events only; with none, both clear.
      w_flags_nxt    = w_uncorr;
      w_fault_ch_nxt = lowest_set_idx(w_uncorr);
    end else begin
      // Later events accumulate but the original culprit is kept.
      w_flags_nxt = r_flags | w_uncorr;
    end
  end

  logic r_warn;
  logic r_fault;
  logic r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OK;
      r_flags    <= '0;
      r_fault_ch <= 1'b0;
      r_warn     <= 1'b0;
      r_fault    <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_flags    <= w_flags_nxt;
      r_fault_ch <= w_fault_ch_nxt;
      r_warn     <= (w_state_nxt == ST_WARN);
      r_fault    <= (w_state_nxt == ST_FAULT);
      r_irq      <= (w_state_nxt != r_state);
    end
  end

  assign warn         = r_warn;
  assign fault        = r_fault;
  assign fault_ch     = r_fault_ch;
  assign uncorr_flags = r_flags;
  assign irq          = r_irq;

endmodule

// File: tb/tb_crc_err_supervisor.sv
module tb_crc_err_supervisor;

  localparam int LP  = 16;
  localparam int CW  = 8;
  localparam int TH0 = 4;
  localparam int TH1 = 16;
  localparam int M_OK = 0, M_WARN = 1, M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  err_detected;
  logic [1:0]  err_corrected;
  logic        fault_ack;
  logic        warn, fault, fault_ch, irq;
  logic [1:0]  uncorr_flags;
  logic [15:0] corr_cnt;

  always #5 clk = ~clk;

  crc_err_supervisor #(
    .NUM_CH        (2),
    .CNT_WIDTH     (CW),
    .CORR_THRESH_0 (TH0),
    .CORR_THRESH_1 (TH1),
    .LEAK_PERIOD   (LP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .err_detected  (err_detected),
    .err_corrected (err_corrected),
    .fault_ack     (fault_ack),
    .warn          (warn),
    .fault         (fault),
    .fault_ch      (fault_ch),
    .uncorr_flags  (uncorr_flags),
    .corr_cnt      (corr_cnt),
    .irq           (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model, advanced once per clock edge
  int       m_cnt [2];
  int       m_th  [2] = '{TH0, TH1};
  int       m_state;
  int       m_leak;
  bit       m_irq;
  bit [1:0] m_flags;
  bit       m_ch;

  task automatic model_edge(input bit r, input bit [1:0] ed, input bit [1:0] ec, input bit ack);
    bit       tick;
    bit [1:0] unc;
    bit       any_ovr;
    int       prev;
    if (r) begin
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_state = M_OK; m_leak = 0; m_irq = 0; m_flags = 0; m_ch = 0;
      return;
    end
    tick   = (m_leak == LP - 1);
    m_leak = (m_leak + 1) % LP;
    unc    = ed & ~ec;
    any_ovr = 0;
    for (int c = 0; c < 2; c++) begin
      if (ec[c] && !tick)                    m_cnt[c] = (m_cnt[c] < 255) ? m_cnt[c] + 1 : 255;
      else if (tick && !ec[c] && m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
      if (m_cnt[c] >= m_th[c]) any_ovr = 1;
    end
    prev = m_state;
    if (prev != M_FAULT) begin
      if (unc != 0) begin
        m_state = M_FAULT; m_flags = unc; m_ch = !unc[0] && unc[1];
      end else begin
        m_state = any_ovr ? M_WARN : M_OK;
      end
    end else if (ack) begin
      m_flags = unc;
      m_ch    = !unc[0] && unc[1];
      if (unc == 0) m_state = any_ovr ? M_WARN : M_OK;
    end else begin
      m_flags = m_flags | unc;
    end
    m_irq = (m_state != prev);
  endtask

  task automatic compare_all();
    chk("cnt0",   corr_cnt[7:0],  m_cnt[0]);
    chk("cnt1",   corr_cnt[15:8], m_cnt[1]);
    chk("warn",   warn,           m_state == M_WARN);
    chk("fault",  fault,          m_state == M_FAULT);
    chk("fch",    fault_ch,       m_ch);
    chk("flags",  uncorr_flags,   m_flags);
    chk("irq",    irq,            m_irq);
  endtask

  task automatic step(input bit r, input bit [1:0] ed, input bit [1:0] ec, input bit ack);
    @(negedge clk);
    rst = r; err_detected = ed; err_corrected = ec; fault_ack = ack;
    @(posedge clk);
    #1;
    model_edge(r, ed, ec, ack);
    compare_all();
  endtask

  initial begin
    bit found;
    rst = 1'b1; err_detected = '0; err_corrected = '0; fault_ack = 1'b0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_cnt",   corr_cnt, 0);
    chk("rst_state", {warn, fault, fault_ch, uncorr_flags, irq}, 0);

    for (int k = 1; k <= 4; k++) begin
      step(0, 2'b00, 2'b01, 0);
      chk("ramp0", corr_cnt[7:0], k);
    end
    chk("warn_on", warn, 1);
    chk("irq_warn", irq, 1);

    found = 0;
    for (int i = 0; i < 2 * LP && !found; i++) begin
      step(0, 0, 0, 0);
      if (irq) found = 1;
    end
    chk("leak_irq_seen", found, 1);
    chk("leak_cnt", corr_cnt[7:0], 3);
    chk("warn_off", warn, 0);

    step(0, 2'b10, 2'b00, 0);
    chk("f1_fault", fault, 1);
    chk("f1_ch", fault_ch, 1);
    chk("f1_flags", uncorr_flags, 2'b10);
    chk("f1_irq", irq, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 2'b01, 2'b00, 0);
    chk("f2_flags", uncorr_flags, 2'b11);
    chk("f2_ch", fault_ch, 1);
    chk("f2_irq", irq, 0);

    step(0, 0, 0, 1);
    chk("ack_fault", fault, 0);
    chk("ack_flags", uncorr_flags, 0);
    chk("ack_irq", irq, 1);
    chk("ack_warn", warn, 0);

    step(0, 2'b10, 2'b00, 0);
    step(0, 2'b01, 2'b00, 1);
    chk("reack_fault", fault, 1);
    chk("reack_ch", fault_ch, 0);
    chk("reack_flags", uncorr_flags, 2'b01);
    step(0, 0, 0, 1);

    for (int i = 0; i < 300; i++) step(0, 2'b00, 2'b10, 0);
    chk("sat1", corr_cnt[15:8], 255);

    found = 0;
    for (int i = 0; i < 2 * LP && !found; i++) begin
      if (m_leak == LP - 1) found = 1;
      else step(0, 2'b00, 2'b10, 0);
    end
    chk("collide_align", found, 1);
    step(0, 2'b00, 2'b10, 0);
    chk("collide", corr_cnt[15:8], 255);

    for (int i = 0; i < 5 * LP; i++) step(0, 0, 0, 0);
    chk("leak_floor", corr_cnt[7:0], 0);

    step(0, 2'b01, 2'b00, 0);
    chk("pre_rst_fault", fault, 1);
    step(1, 0, 0, 0);
    chk("rst_f_cnt", corr_cnt, 0);
    chk("rst_f_state", {warn, fault, fault_ch, uncorr_flags, irq}, 0);
    step(0, 0, 0, 0);
    chk("rst_f_ok", fault, 0);

    for (int i = 0; i < 3000; i++) begin
      bit [1:0] ec, ed;
      bit       r, ack;
      r   = ($urandom_range(0, 499) == 0);
      ack = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < 2; c++) begin
        ec[c] = ($urandom_range(0, 5) == 0);
        ed[c] = ec[c] | ($urandom_range(0, 39) == 0);
      end
      step(r, ed, ec, ack);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crc_err_supervisor.md
Name: crc_err_supervisor

Overview:
- Downstream safety-monitor stage for the crc_mem instances in dut.
- Consumes each memory's err_detected/err_corrected strobes and counts corrected errors per channel, with leaky-bucket decay.
- Escalates per-channel thresholds to a global WARN/FAULT state with a sticky fault and a software acknowledge handshake.
- Channel 0 = MEM1 (ASIL-D, tight threshold); channel 1 = MEM2 (ASIL-B, loose threshold).

Parameters:
- NUM_CH, 2, number of monitored memory channels (fixed at 2 in this revision).
- CNT_WIDTH, 8, width of each corrected-error counter.
- CORR_THRESH_0, 4, corrected-error count at which channel 0 raises WARN.
- CORR_THRESH_1, 16, corrected-error count at which channel 1 raises WARN.
- LEAK_PERIOD, 1024, cycles between leak ticks; legal range 2..2**16.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- err_detected  in  NUM_CH  per-channel error-detected strobe from crc_mem.
- err_corrected  in  NUM_CH  per-channel error-corrected strobe from crc_mem.
- fault_ack  in  1  single-cycle acknowledge of a latched fault.
- warn  out  1  registered; any channel at or above its threshold.
- fault  out  1  registered; sticky uncorrectable-error state.
- fault_ch  out  1  index of the first channel that caused the current fault.
- uncorr_flags  out  NUM_CH  sticky per-channel uncorrectable flags.
- corr_cnt  out  NUM_CH*CNT_WIDTH  packed counters; channel 0 in the LSBs.
- irq  out  1  one-cycle pulse on every state-machine state change.

Behaviour:
- Reset: synchronous, active-high. On a clk edge with rst=1, every output goes to 0: warn, fault, fault_ch, uncorr_flags, corr_cnt, irq. The leak counter also goes to 0 and the FSM to ST_OK. Reset mid-fault clears everything; the fault_ack handshake is not required.
- Event decode, per channel c, in cycle N:
  - corr[c] = err_corrected[c]. This applies even when err_detected[c]=0.
  - uncorr[c] = err_detected[c] & ~err_corrected[c].
- Latency: an event in cycle N is visible on corr_cnt/warn/fault/uncorr_flags/irq in cycle N+1. There is no input register.
- Counters:
  - corr[c] increments the counter, saturating at 2**CNT_WIDTH-1; it never wraps.
- Leak:
  - The free-running leak counter counts 0..LEAK_PERIOD-1 and wraps.
  - On wrap, a one-cycle tick decrements every nonzero corr counter. A counter at 0 stays at 0.
  - Tick and corr on the same channel in the same cycle: the counter is unchanged, including when it is saturated.
- Per-channel over-threshold: ovr[c] = (next counter value >= CORR_THRESH_c). warn = OR of ovr in state ST_WARN; warn=0 in ST_FAULT.
- FSM states and transitions:
  - ST_OK -> ST_FAULT if any uncorr, else -> ST_WARN if any ovr.
  - ST_WARN -> ST_FAULT if any uncorr, else -> ST_OK when no ovr (counters have leaked below threshold).
  - ST_FAULT: stays until fault_ack=1.
  - On ack with no uncorr in the same cycle: -> ST_WARN if any ovr, else ST_OK. uncorr_flags clear and fault_ch clears to 0.
  - On ack with uncorr in the same cycle: stay in ST_FAULT. uncorr_flags are reloaded with only the new events, and fault_ch is updated to the new lowest-index channel.
  - fault_ack outside ST_FAULT is ignored.
- Fault latching:
  - On entry to ST_FAULT, fault_ch = lowest-index channel with uncorr.
  - Later uncorr events while in ST_FAULT set their uncorr_flags bit but do not change fault_ch.
  - Corrected counting and leak continue in every state.
- irq: asserted in cycle N+1 whenever the state differs from its value in cycle N; never asserted two cycles in a row unless the state changed twice.
- Simultaneous uncorr on both channels entering fault: fault_ch=0, uncorr_flags=2'b11.

Decomposition:
- Package crc_sup_pkg:
  - state enum sup_state_e {ST_OK, ST_WARN, ST_FAULT}.
  - CH_MEM1=0 and CH_MEM2=1 constants.
  - Function for the lowest-set-bit index.
- Sub-module crc_err_counter, one instance per channel, generate loop:
  - Inputs: inc, leak, threshold. Output: saturating count and ovr.
- Top-level logic: leak timer, FSM, fault latching, irq.

Test Plan:
- Reset, then 4 err_corrected pulses on ch0 (CORR_THRESH_0=4): corr_cnt[7:0]=1,2,3,4; warn=1 and irq pulse in the cycle after the 4th pulse; state ST_WARN.
- Hold ch0 at 4 and wait for one leak tick (LEAK_PERIOD=16 in the bench): count=3, warn=0, irq pulse, state ST_OK.
- err_detected=1 / err_corrected=0 on ch1 at cycle N: fault=1, fault_ch=1, uncorr_flags=2'b10, irq at N+1. A later ch0 uncorr gives uncorr_flags=2'b11 with fault_ch still 1.
- fault_ack pulse with no new events: fault=0, uncorr_flags=0, return to ST_OK (or ST_WARN if a counter is over threshold), irq pulse. fault_ack together with a ch0 uncorr: fault stays 1, fault_ch=0, uncorr_flags=2'b01.
- Saturation and collision:
  - 300 err_corrected pulses on ch1: count holds at 255.
  - A corr pulse coincident with a leak tick: count unchanged.
  - Leak at count 0: stays 0.
- rst=1 asserted while in ST_FAULT with nonzero counters: next cycle all outputs are 0 and the state is ST_OK; fault_ack is not needed.
